cpu_host_ctrl: RTL and testbench
================================

# cpu_host_ctrl

Host-side sequencer for the pipelined RISC-V `cpu`. It accepts commands over a valid/ready stream and performs four operations:
- load instruction words through the instruction-memory external port;
- load data words through the data-memory external port;
- run the core by holding `enable` high for an exact number of cycles;
- dump a range of data memory back to the host over a valid/ready response stream.

It sits between the testbench or host link and the `cpu` top. It is the only driver of the core's `enable` and external memory ports.

## Interface
- `RD_LAT`, 1, data-memory external read latency in cycles (≥1)
- `CNT_W`, 32, width of the run-cycle and dump-word counters

- `clk`  in  1  single clock, rising edge
- `arst`  in  1  asynchronous reset, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high
- `cmd_op`  in  2  0 LOAD_IMEM, 1 LOAD_DMEM, 2 RUN, 3 DUMP
- `cmd_addr`  in  64  byte address (LOAD/DUMP start)
- `cmd_data`  in  64  LOAD: write word (IMEM uses [31:0]); RUN: cycle count [CNT_W-1:0]; DUMP: word count [CNT_W-1:0]
- `rsp_valid`  out  1  dump word available
- `rsp_ready`  in  1  host accepts dump word
- `rsp_data`  out  64  dump word
- `rsp_last`  out  1  final word of a dump
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on command completion
- `cpu_enable`  out  1  to `cpu.enable`
- `addr_ext`, `wen_ext`, `ren_ext`, `wdata_ext[31:0]`  out  —  instruction-memory external port
- `rdata_ext`  in  32  unused, reserved
- `addr_ext_2`, `wen_ext_2`, `ren_ext_2`, `wdata_ext_2[63:0]`  out  —  data-memory external port
- `rdata_ext_2`  in  64  data-memory read word

## Operation
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT.
- `cmd_ready` = (state == IDLE). A command is accepted only on the `cmd_valid && cmd_ready` cycle. Its fields are registered on acceptance.
- **LOAD_I / LOAD_D**: one state cycle.
  - The matching `wen_ext*` is high, with the registered address and data.
  - The state then returns to IDLE.
- **RUN N**:
  - `cpu_enable` is high for exactly N cycles, then the state returns to IDLE.
  - N = 0 goes from accept straight to IDLE with no `enable` cycle.
  - All external-port strobes are low throughout RUN.
- **DUMP addr, N**: per word:
  - DUMP_REQ: one cycle with `ren_ext_2` = 1 and `addr_ext_2` = current address.
  - DUMP_WAIT: RD_LAT cycles. `rdata_ext_2` is captured into `rsp_data` at the end of the last one.
  - DUMP_OUT: `rsp_valid` is held high until `rsp_ready`.
  - On handshake the address advances by 8 and the remaining count decrements. The state goes to DUMP_REQ, or to IDLE if the count reaches 0.
  - `rsp_last` = 1 with the final word.
  - N = 0 returns to IDLE with no response.
- Address and count arithmetic is modulo 2^64 and 2^CNT_W respectively. A dump wraps silently past 2^64−8.
- `done` is registered and is high in the first IDLE cycle after any command, including N = 0 commands.
- Never more than one external strobe is high in a cycle. `cpu_enable` and external strobes are never high together.

## Timing
- Reset (asynchronous, immediate): state IDLE; `cmd_ready` = 1; all other outputs 0, including `rsp_data`, addresses and write data.
- Reset mid-command aborts it: strobes and `cpu_enable` drop immediately and no `done` is produced.
- Let T be the accept cycle:
  - LOAD: write strobe at T+1; `done` and `cmd_ready` at T+2.
  - RUN N: `cpu_enable` at T+1..T+N; `done` at T+N+1.
  - DUMP, first word: `ren_ext_2` at T+1; `rsp_valid` at T+2+RD_LAT. Each further word takes a minimum of RD_LAT+2 cycles after the previous handshake.
- Every output is a register or decoded from the state register. There is no combinational path from `rsp_ready` or `cmd_valid` to any output.

## Structure
- Package `cpu_host_ctrl_pkg` holds:
  - the `cmd_op` encoding constants;
  - the state enum;
  - the dump stride constant (8) and the word-size constants.
- Sub-module `down_counter` (CNT_W wide, with load, decrement and zero flag) is shared by the RUN cycle count and the DUMP word count.

## Test plan
- Reset then LOAD_IMEM addr 0x10, data 0x00500093 → `wen_ext` one cycle at T+1 with `addr_ext` = 0x10 and `wdata_ext` = 0x00500093; `done` at T+2.
- RUN 5 → `cpu_enable` high exactly 5 consecutive cycles; `done` one cycle later. RUN 0 → no `enable` cycle, `done` at T+1.
- LOAD_DMEM words 0x11, 0x22, 0x33 at 0x0/0x8/0x10, then DUMP 0x0, count 3 with `rsp_ready` tied high → `rsp_data` 0x11, 0x22, 0x33; `rsp_last` only on 0x33.
- DUMP with `rsp_ready` low for 4 cycles on word 2 → `rsp_valid` and `rsp_data` held stable, no extra `ren_ext_2` pulse, no word lost or duplicated.
- `arst` asserted at the 3rd cycle of RUN 10 → `cpu_enable` low in the same cycle, no `done`, `cmd_ready` = 1 after release.
- `cmd_valid` held high during RUN → the second command is accepted only on the `done` cycle, when `cmd_ready` = 1.

Source files
------------

// File: rtl/cpu_host_ctrl_pkg.sv
// Shared definitions for the host-side sequencer of the pipelined RISC-V core:
// command opcodes, sequencer states and memory word geometry.
package cpu_host_ctrl_pkg;

  localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
  localparam logic [1:0] OP_LOAD_DMEM = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_DUMP      = 2'd3;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned IMEM_WORD_W = 32;
  localparam int unsigned DMEM_WORD_W = 64;

  localparam logic [ADDR_W-1:0] DUMP_STRIDE = 64'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DUMP_REQ,
    S_DUMP_WAIT,
    S_DUMP_OUT
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with zero flag; shared by the RUN cycle count and
// the DUMP word count.
module down_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host command sequencer: loads instruction/data memory, runs the core for an
// exact cycle count and streams a range of data memory back to the host.
module cpu_host_ctrl
  import cpu_host_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DMEM_WORD_W-1:0] cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DMEM_WORD_W-1:0] rsp_data,
  output logic                   rsp_last,
  output logic                   busy,
  output logic                   done,
  output logic                   cpu_enable,
  output logic [ADDR_W-1:0]      addr_ext,
  output logic                   wen_ext,
  output logic                   ren_ext,
  output logic [IMEM_WORD_W-1:0] wdata_ext,
  input  logic [IMEM_WORD_W-1:0] rdata_ext,
  output logic [ADDR_W-1:0]      addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic [DMEM_WORD_W-1:0] wdata_ext_2,
  input  logic [DMEM_WORD_W-1:0] rdata_ext_2
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t                   state;
  state_t                   next_state;
  logic [ADDR_W-1:0]        addr_q;
  logic [DMEM_WORD_W-1:0]   data_q;
  logic [DMEM_WORD_W-1:0]   rsp_data_q;
  logic [LAT_W-1:0]         lat_cnt;
  logic                     done_q;
  logic                     done_next;
  logic                     accept;
  logic                     cnt_load;
  logic                     cnt_dec;
  logic                     cnt_zero;
  logic [CNT_W-1:0]         cnt_value;
  logic [CNT_W-1:0]         cmd_cnt;
  logic                     cmd_cnt_zero;
  logic                     unused_rdata;

  assign unused_rdata = ^rdata_ext;

  assign accept       = cmd_valid && (state == S_IDLE);
  assign cmd_cnt      = cmd_data[CNT_W-1:0];
  assign cmd_cnt_zero = (cmd_cnt == '0);
  // Counter holds "remaining minus one" so the zero flag marks the final
  // RUN cycle / final dump word directly.
  assign cnt_value    = cmd_cnt - CNT_W'(1);
  assign cnt_load     = accept;

  down_counter #(
    .W(CNT_W)
  ) u_count (
    .clk  (clk),
    .arst (arst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .value(cnt_value),
    .count(),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= done_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_dec    = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD_IMEM: next_state = S_LOAD_I;
            OP_LOAD_DMEM: next_state = S_LOAD_D;
            OP_RUN: begin
              if (cmd_cnt_zero) done_next  = 1'b1;
              else              next_state = S_RUN;
            end
            OP_DUMP: begin
              if (cmd_cnt_zero) done_next  = 1'b1;
              else              next_state = S_DUMP_REQ;
            end
          endcase
        end
      end
      S_LOAD_I, S_LOAD_D: begin
        next_state = S_IDLE;
        done_next  = 1'b1;
      end
      S_RUN: begin
        if (cnt_zero) begin
          next_state = S_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DUMP_REQ: next_state = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        if (lat_cnt == '0) next_state = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (rsp_ready) begin
          if (cnt_zero) begin
            next_state = S_IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_dec    = 1'b1;
            next_state = S_DUMP_REQ;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      addr_q     <= '0;
      data_q     <= '0;
      lat_cnt    <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end else if (state == S_DUMP_OUT && rsp_ready) begin
        addr_q <= addr_q + DUMP_STRIDE;
      end
      if (state == S_DUMP_REQ) begin
        lat_cnt <= LAT_W'(RD_LAT - 1);
      end else if (state == S_DUMP_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (state == S_DUMP_WAIT && lat_cnt == '0) begin
        rsp_data_q <= rdata_ext_2;
      end
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign cpu_enable  = (state == S_RUN);
  assign wen_ext     = (state == S_LOAD_I);
  assign ren_ext     = 1'b0;
  assign addr_ext    = addr_q;
  assign wdata_ext   = data_q[IMEM_WORD_W-1:0];
  assign wen_ext_2   = (state == S_LOAD_D);
  assign ren_ext_2   = (state == S_DUMP_REQ);
  assign addr_ext_2  = addr_q;
  assign wdata_ext_2 = data_q;
  assign rsp_valid   = (state == S_DUMP_OUT);
  assign rsp_last    = (state == S_DUMP_OUT) && cnt_zero;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Directed plus randomized bench for cpu_host_ctrl with a data-memory device
// model and a word-addressed reference memory kept by the host side.
module tb_cpu_host_ctrl;
  import cpu_host_ctrl_pkg::*;

  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        arst;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [63:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        done;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = '0;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] dev_mem [128];
  logic [63:0] rd_pipe [RD_LAT];

  cpu_host_ctrl #(
    .RD_LAT(RD_LAT),
    .CNT_W (32)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .done       (done),
    .cpu_enable (cpu_enable),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .rdata_ext  (rdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .ren_ext_2  (ren_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2)
  );

  always #5 clk = ~clk;

  // Data-memory device: word indexed, RD_LAT-cycle read pipeline, garbage when idle.
  always @(posedge clk) begin
    if (wen_ext_2) dev_mem[addr_ext_2[9:3]] <= wdata_ext_2;
    rd_pipe[0] <= ren_ext_2 ? dev_mem[addr_ext_2[9:3]] : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rdata_ext_2 = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      chk1("strobe_exclusive",
           $countones({wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable}) <= 1, 1'b1);
    end
  end

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] d);
    chk1("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [63:0] a, input logic [63:0] d);
    issue(op, a, d);
    chk1("ld_wen_i", wen_ext, op == OP_LOAD_IMEM);
    chk1("ld_wen_d", wen_ext_2, op == OP_LOAD_DMEM);
    chk1("ld_busy", busy, 1'b1);
    chk1("ld_done_early", done, 1'b0);
    if (op == OP_LOAD_IMEM) begin
      chk("ld_addr_i", addr_ext, a);
      chk("ld_wdata_i", 64'(wdata_ext), {32'h0, d[31:0]});
    end else begin
      chk("ld_addr_d", addr_ext_2, a);
      chk("ld_wdata_d", wdata_ext_2, d);
      ref_mem[a] = d;
    end
    step();
    chk1("ld_wen_i_off", wen_ext, 1'b0);
    chk1("ld_wen_d_off", wen_ext_2, 1'b0);
    chk1("ld_done", done, 1'b1);
    chk1("ld_ready_back", cmd_ready, 1'b1);
  endtask

  task automatic do_run(input int unsigned n);
    issue(OP_RUN, 64'h40, 64'(n));
    for (int unsigned i = 0; i < n; i++) begin
      chk1("run_enable", cpu_enable, 1'b1);
      chk1("run_ready_low", cmd_ready, 1'b0);
      chk1("run_done_early", done, 1'b0);
      step();
    end
    chk1("run_enable_off", cpu_enable, 1'b0);
    chk1("run_done", done, 1'b1);
    chk1("run_ready_back", cmd_ready, 1'b1);
  endtask

  task automatic run_dump(input logic [63:0] a, input int unsigned n,
                          input int unsigned pct, input int stall_word);
    int unsigned got = 0;
    int unsigned cyc = 0;
    int unsigned rens = 0;
    int unsigned stall_left = 4;
    int          first_cyc = -1;
    logic        pend = 1'b0;
    logic [63:0] pdata = '0;
    issue(OP_DUMP, a, 64'(n));
    if (n == 0) begin
      chk1("dump0_done", done, 1'b1);
      chk1("dump0_valid", rsp_valid, 1'b0);
      chk1("dump0_ren", ren_ext_2, 1'b0);
      chk1("dump0_busy", busy, 1'b0);
      return;
    end
    while (got < n && cyc < 100 * n + 20) begin
      if (ren_ext_2) begin
        rens++;
        chk("dump_raddr", addr_ext_2, a + 64'(got) * 64'd8);
      end
      if (pend) begin
        chk1("hold_valid", rsp_valid, 1'b1);
        chk("hold_data", rsp_data, pdata);
      end
      if (rsp_valid && first_cyc < 0) first_cyc = int'(cyc);
      if (rsp_valid && int'(got) == stall_word && stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = ($urandom_range(99) < pct);
      end
      pend  = rsp_valid && !rsp_ready;
      pdata = rsp_data;
      if (rsp_valid && rsp_ready) begin
        chk("dump_data", rsp_data, ref_read(a + 64'(got) * 64'd8));
        chk1("dump_last", rsp_last, got == n - 1);
        got++;
      end
      step();
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("dump_words", 64'(got), 64'(n));
    chk("dump_ren_pulses", 64'(rens), 64'(n));
    chk("dump_first_latency", 64'(first_cyc), 64'(RD_LAT + 1));
    chk1("dump_done", done, 1'b1);
    chk1("dump_valid_off", rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    #1;
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_enable", cpu_enable, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_addr_ext", addr_ext, 64'h0);
    chk("rst_addr_ext_2", addr_ext_2, 64'h0);
    chk("rst_wdata_ext_2", wdata_ext_2, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 arst = 1'b0;

    // Instruction load and done pulse width.
    do_load(OP_LOAD_IMEM, 64'h10, 64'h0000_0000_0050_0093);
    step();
    chk1("done_one_cycle", done, 1'b0);

    do_run(5);
    do_run(0);
    do_run(1);

    do_load(OP_LOAD_DMEM, 64'h0,  64'h11);
    do_load(OP_LOAD_DMEM, 64'h8,  64'h22);
    do_load(OP_LOAD_DMEM, 64'h10, 64'h33);
    run_dump(64'h0, 3, 100, -1);
    run_dump(64'h0, 3, 100, 1);

    // Address wraps past the top of the 64-bit space.
    do_load(OP_LOAD_DMEM, 64'hFFFF_FFFF_FFFF_FFF8, 64'hA5A5_0000_FFFF_1234);
    do_load(OP_LOAD_DMEM, 64'h0, 64'h0BAD_CAFE_0000_0001);
    run_dump(64'hFFFF_FFFF_FFFF_FFF8, 2, 100, -1);
    run_dump(64'h20, 0, 100, -1);

    // Command held valid during RUN is taken only on the done cycle.
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    cmd_addr  = 64'h0;
    cmd_data  = 64'd3;
    step();
    cmd_op   = OP_LOAD_IMEM;
    cmd_addr = 64'h20;
    cmd_data = 64'h0000_0000_0000_ABCD;
    for (int unsigned i = 0; i < 3; i++) begin
      chk1("held_enable", cpu_enable, 1'b1);
      chk1("held_ready_low", cmd_ready, 1'b0);
      chk1("held_no_wen", wen_ext, 1'b0);
      step();
    end
    chk1("held_done", done, 1'b1);
    chk1("held_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk1("held_wen", wen_ext, 1'b1);
    chk("held_addr", addr_ext, 64'h20);
    chk("held_wdata", 64'(wdata_ext), 64'h0000_ABCD);
    step();
    chk1("held_done2", done, 1'b1);

    // Randomized phase: fill a window of data memory, then mix commands.
    for (int unsigned k = 0; k <= 120; k++) begin
      do_load(OP_LOAD_DMEM, 64'(k) * 64'd8, {$urandom, $urandom});
    end
    for (int unsigned k = 0; k < 30; k++) begin
      case ($urandom_range(3))
        0: do_load(OP_LOAD_IMEM, {$urandom, $urandom}, {$urandom, $urandom});
        1: do_load(OP_LOAD_DMEM, 64'($urandom_range(0, 120)) * 64'd8, {$urandom, $urandom});
        2: do_run($urandom_range(0, 12));
        default: run_dump(64'($urandom_range(0, 114)) * 64'd8, $urandom_range(0, 6),
                          $urandom_range(40, 100), -1);
      endcase
    end

    // Asynchronous reset in the third RUN cycle aborts the command.
    run_dump(64'h8, 1, 100, -1);
    issue(OP_RUN, 64'h40, 64'd10);
    step();
    step();
    chk1("abort_pre_enable", cpu_enable, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk1("abort_enable", cpu_enable, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", cmd_ready, 1'b1);
    chk("abort_rsp_data", rsp_data, 64'h0);
    chk("abort_addr", addr_ext_2, 64'h0);
    chk("abort_wdata", wdata_ext_2, 64'h0);
    @(posedge clk);
    #1 arst = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      chk1("abort_no_done", done, 1'b0);
      chk1("abort_no_enable", cpu_enable, 1'b0);
      chk1("abort_ready_after", cmd_ready, 1'b1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
